// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: transfer sequencer sitting in front of the SPI bit shifter.
// Qualifies send requests against mode/enable, pulses the shifter load strobe,
// holds slave-select low for one 8-bit frame and pulses the receive strobe at
// frame end. One request can be queued while a frame is in flight.
module spi_slave_ctrl #(
  parameter int DIV_W = 12,
  parameter int CNT_W = DIV_W + 3
) (
  input  logic             PCLK,
  input  logic             PRESET_n,
  input  logic             mstr_i,
  input  logic             spe_i,
  input  logic             spiswai_i,
  input  logic [1:0]       spi_mode_i,
  input  logic             start_i,
  input  logic [DIV_W-1:0] baud_div_i,
  output logic             ss_o,
  output logic             send_data_o,
  output logic             receive_data_o,
  output logic             tip_o,
  output logic             pending_o,
  output logic             abort_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_XFER = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_pending;
  logic               w_pending_nxt;
  logic               w_abort;
  logic               w_enable;
  logic [DIV_W-1:0]   r_eff_div;
  logic [DIV_W-1:0]   w_div_clamped;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_last;
  logic               r_ss;
  logic               r_send;
  logic               r_recv;
  logic               r_tip;
  logic               r_abort;

  // Transfers may run only in master mode, when enabled, and in RUN or in
  // WAIT with stop-in-wait cleared.
  assign w_enable = mstr_i & spe_i &
                    ((spi_mode_i == 2'b00) | ((spi_mode_i == 2'b01) & ~spiswai_i));

  // Divisors below 2 clamp to 2; odd divisors round down so SCLK stays symmetric.
  assign w_div_clamped = (baud_div_i < {{(DIV_W-2){1'b0}}, 2'b10})
                         ? {{(DIV_W-2){1'b0}}, 2'b10}
                         : {baud_div_i[DIV_W-1:1], 1'b0};

  // Last counter value of the frame: 8*eff_div - 1 (cannot overflow CNT_W).
  assign w_cnt_last = CNT_W'({r_eff_div, 3'b000}) - {{(CNT_W-1){1'b0}}, 1'b1};

  // State register.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, request-queue and abort decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_abort       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((start_i | r_pending) & w_enable) begin
          w_state_nxt   = S_LOAD;
          w_pending_nxt = 1'b0;
        end else if (start_i) begin
          w_pending_nxt = 1'b1;
        end else begin
          w_pending_nxt = r_pending;
        end
      end
      S_LOAD: begin
        if (start_i) begin
          w_pending_nxt = 1'b1;
        end else begin
          w_pending_nxt = r_pending;
        end
        if (!w_enable) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (start_i) begin
          w_pending_nxt = 1'b1;
        end else begin
          w_pending_nxt = r_pending;
        end
        if (!w_enable) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (r_cnt == w_cnt_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_XFER;
        end
      end
      S_DONE: begin
        if (start_i) begin
          w_pending_nxt = 1'b1;
        end else begin
          w_pending_nxt = r_pending;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // Pending flag, frame counter and divisor latched at LOAD.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_pending <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
      r_eff_div <= {{(DIV_W-2){1'b0}}, 2'b10};
    end else begin
      r_pending <= w_pending_nxt;
      if ((r_state == S_XFER) && (w_state_nxt == S_XFER)) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= {CNT_W{1'b0}};
      end
      if (r_state == S_LOAD) begin
        r_eff_div <= w_div_clamped;
      end else begin
        r_eff_div <= r_eff_div;
      end
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      r_ss    <= 1'b1;
      r_send  <= 1'b0;
      r_recv  <= 1'b0;
      r_tip   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_ss    <= (w_state_nxt != S_XFER);
      r_send  <= (w_state_nxt == S_LOAD);
      r_recv  <= (w_state_nxt == S_DONE);
      r_tip   <= (w_state_nxt == S_XFER);
      r_abort <= w_abort;
    end
  end

  assign ss_o           = r_ss;
  assign send_data_o    = r_send;
  assign receive_data_o = r_recv;
  assign tip_o          = r_tip;
  assign pending_o      = r_pending;
  assign abort_o        = r_abort;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: frame timing, divisor clamp, request
// queue, abort, mode gating and asynchronous reset mid-frame.
module tb_spi_slave_ctrl;

  localparam int DIV_W = 12;

  logic             PCLK;
  logic             PRESET_n;
  logic             mstr_i;
  logic             spe_i;
  logic             spiswai_i;
  logic [1:0]       spi_mode_i;
  logic             start_i;
  logic [DIV_W-1:0] baud_div_i;
  logic             ss_o;
  logic             send_data_o;
  logic             receive_data_o;
  logic             tip_o;
  logic             pending_o;
  logic             abort_o;

  int n_checks;
  int n_errors;

  spi_slave_ctrl #(.DIV_W(DIV_W)) dut (
    .PCLK           (PCLK),
    .PRESET_n       (PRESET_n),
    .mstr_i         (mstr_i),
    .spe_i          (spe_i),
    .spiswai_i      (spiswai_i),
    .spi_mode_i     (spi_mode_i),
    .start_i        (start_i),
    .baud_div_i     (baud_div_i),
    .ss_o           (ss_o),
    .send_data_o    (send_data_o),
    .receive_data_o (receive_data_o),
    .tip_o          (tip_o),
    .pending_o      (pending_o),
    .abort_o        (abort_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Count cycles with ss_o low, bounded; leaves us in the first cycle ss_o is high.
  task automatic count_low(output int n);
    n = 0;
    while (ss_o == 1'b0 && n < 300) begin
      n++;
      step();
    end
  endtask

  // Pulse start_i and check load strobe, frame length and receive strobe.
  task automatic run_frame(input string tag, input int exp_len);
    int n;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk({tag, "_send"}, 32'(send_data_o), 32'd1);
    chk({tag, "_ss_load"}, 32'(ss_o), 32'd1);
    step();
    chk({tag, "_tip"}, 32'(tip_o), 32'd1);
    count_low(n);
    chk({tag, "_len"}, 32'(n), 32'(exp_len));
    chk({tag, "_recv"}, 32'(receive_data_o), 32'd1);
    chk({tag, "_tip_done"}, 32'(tip_o), 32'd0);
    step();
    chk({tag, "_recv_off"}, 32'(receive_data_o), 32'd0);
    chk({tag, "_ss_idle"}, 32'(ss_o), 32'd1);
  endtask

  initial begin
    int n;
    int sends;
    n_checks   = 0;
    n_errors   = 0;
    PRESET_n   = 1'b0;
    mstr_i     = 1'b0;
    spe_i      = 1'b0;
    spiswai_i  = 1'b0;
    spi_mode_i = 2'b00;
    start_i    = 1'b0;
    baud_div_i = 12'd4;
    #12;
    chk("rst_ss", 32'(ss_o), 32'd1);
    chk("rst_send", 32'(send_data_o), 32'd0);
    chk("rst_recv", 32'(receive_data_o), 32'd0);
    chk("rst_tip", 32'(tip_o), 32'd0);
    chk("rst_pend", 32'(pending_o), 32'd0);
    chk("rst_abort", 32'(abort_o), 32'd0);
    step();
    PRESET_n = 1'b1;
    mstr_i   = 1'b1;
    spe_i    = 1'b1;
    step();

    // 1. basic frame, divisor 4 -> 32 cycles
    run_frame("basic", 32);

    // 2. divisor clamp / rounding
    baud_div_i = 12'd0;  run_frame("div0", 16);
    baud_div_i = 12'd1;  run_frame("div1", 16);
    baud_div_i = 12'd5;  run_frame("div5", 32);

    // 3. queued request while transferring (divisor 2 -> 16 cycles)
    baud_div_i = 12'd2;
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("q_send1", 32'(send_data_o), 32'd1);
    step();                       // XFER count 0
    step(); step(); step();       // XFER count 3
    baud_div_i = 12'd8;           // must not affect the running frame
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("q_pend", 32'(pending_o), 32'd1);
    start_i = 1'b1; step(); start_i = 1'b0;   // dropped
    count_low(n);
    chk("q_len_remaining", 32'(n), 32'd11);
    chk("q_recv1", 32'(receive_data_o), 32'd1);
    chk("q_pend_done", 32'(pending_o), 32'd1);
    baud_div_i = 12'd2;
    step();                       // IDLE
    chk("q_idle_send", 32'(send_data_o), 32'd0);
    chk("q_idle_ss", 32'(ss_o), 32'd1);
    step();                       // second LOAD
    chk("q_send2", 32'(send_data_o), 32'd1);
    chk("q_pend_clr", 32'(pending_o), 32'd0);
    step();
    count_low(n);
    chk("q_len2", 32'(n), 32'd16);
    chk("q_recv2", 32'(receive_data_o), 32'd1);
    sends = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (send_data_o) sends++;
    end
    chk("q_third_dropped", 32'(sends), 32'd0);

    // 4. abort at XFER cycle 5
    baud_div_i = 12'd4;
    start_i = 1'b1; step(); start_i = 1'b0;
    step();                       // XFER count 0
    for (int i = 0; i < 5; i++) step();
    chk("ab_ss_pre", 32'(ss_o), 32'd0);
    spe_i = 1'b0;
    step();
    chk("ab_ss", 32'(ss_o), 32'd1);
    chk("ab_tip", 32'(tip_o), 32'd0);
    chk("ab_abort", 32'(abort_o), 32'd1);
    chk("ab_recv", 32'(receive_data_o), 32'd0);
    step();
    chk("ab_abort_off", 32'(abort_o), 32'd0);
    chk("ab_recv2", 32'(receive_data_o), 32'd0);
    spe_i = 1'b1;
    step();

    // 5. mode gating: WAIT with stop-in-wait blocks the request
    spi_mode_i = 2'b01;
    spiswai_i  = 1'b1;
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("mg_nosend", 32'(send_data_o), 32'd0);
    chk("mg_pend", 32'(pending_o), 32'd1);
    step(); step();
    chk("mg_still_idle", 32'(ss_o), 32'd1);
    spiswai_i = 1'b0;
    step();
    chk("mg_send", 32'(send_data_o), 32'd1);
    chk("mg_pend_clr", 32'(pending_o), 32'd0);
    step();
    count_low(n);
    chk("mg_len", 32'(n), 32'd32);
    spi_mode_i = 2'b00;
    step();

    // 6. reset mid-frame with a queued request
    start_i = 1'b1; step(); start_i = 1'b0;
    step();                       // XFER count 0
    for (int i = 0; i < 5; i++) step();
    start_i = 1'b1; step(); start_i = 1'b0;   // count 6, pending set
    chk("rs_pend_set", 32'(pending_o), 32'd1);
    for (int i = 0; i < 4; i++) step();       // count 10
    chk("rs_ss_pre", 32'(ss_o), 32'd0);
    #1;
    PRESET_n = 1'b0;
    #1;
    chk("rs_ss_async", 32'(ss_o), 32'd1);
    chk("rs_tip", 32'(tip_o), 32'd0);
    chk("rs_send", 32'(send_data_o), 32'd0);
    chk("rs_recv", 32'(receive_data_o), 32'd0);
    chk("rs_abort", 32'(abort_o), 32'd0);
    chk("rs_pend", 32'(pending_o), 32'd0);
    step(); step();
    PRESET_n = 1'b1;
    sends = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (send_data_o) sends++;
    end
    chk("rs_no_load", 32'(sends), 32'd0);
    chk("rs_ss_idle", 32'(ss_o), 32'd1);
    chk("rs_pend_idle", 32'(pending_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
